// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between VProc masters.
// Grant is held for a whole single or burst transfer.
module vproc_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_MASTERS*32-1:0] MAddr,
    input  logic [NUM_MASTERS-1:0]    MWE,
    input  logic [NUM_MASTERS-1:0]    MRD,
    input  logic [NUM_MASTERS*32-1:0] MDataOut,
    input  logic [NUM_MASTERS*12-1:0] MBurst,
    output logic [31:0]               MDataIn,
    output logic [NUM_MASTERS-1:0]    MWRAck,
    output logic [NUM_MASTERS-1:0]    MRDAck,
    output logic [31:0]               SAddr,
    output logic                      SWE,
    output logic                      SRD,
    output logic [31:0]               SDataOut,
    output logic [11:0]               SBurst,
    input  logic [31:0]               SDataIn,
    input  logic                      SWRAck,
    input  logic                      SRDAck,
    output logic [NUM_MASTERS-1:0]    Grant,
    output logic                      Busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [IDX_WIDTH-1:0] grant_idx, grant_n;
    logic [IDX_WIDTH-1:0] last_idx, last_n;
    logic [11:0]          beat_cnt, beat_n;

    logic [NUM_MASTERS-1:0] req;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic [IDX_WIDTH-1:0]   sel_hi;
    logic                   hi_found;
    logic [11:0]            sel_burst;
    logic                   wr_ack;
    logic                   rd_ack;

    assign req     = MWE | MRD;
    assign MDataIn = SDataIn;

    // Nearest requester above last_idx wins, else the lowest one (wrap).
    always_comb begin
        sel_idx   = '0;
        sel_hi    = '0;
        hi_found  = 1'b0;
        sel_burst = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_idx = IDX_WIDTH'(i);
                if (IDX_WIDTH'(i) > last_idx) begin
                    sel_hi   = IDX_WIDTH'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (hi_found)
            sel_idx = sel_hi;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_idx == IDX_WIDTH'(i))
                sel_burst = MBurst[12*i +: 12];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_WIDTH'(NUM_MASTERS - 1);
            beat_cnt  <= '0;
        end else begin
            state     <= state_n;
            grant_idx <= grant_n;
            last_idx  <= last_n;
            beat_cnt  <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_idx;
        last_n  = last_idx;
        beat_n  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = BUSY;
                    grant_n = sel_idx;
                    beat_n  = (sel_burst == 12'd0) ? 12'd1 : sel_burst;
                end
            end
            BUSY: begin
                if (!(SWE | SRD)) begin
                    state_n = IDLE;
                    last_n  = grant_idx;
                end else if (wr_ack | rd_ack) begin
                    if (beat_cnt > 12'd1) begin
                        beat_n = beat_cnt - 12'd1;
                    end else begin
                        state_n = IDLE;
                        last_n  = grant_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    // Slave side is a mux of the granted master, zero when idle.
    always_comb begin
        Busy     = (state == BUSY);
        Grant    = '0;
        SAddr    = '0;
        SWE      = 1'b0;
        SRD      = 1'b0;
        SDataOut = '0;
        SBurst   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Busy && grant_idx == IDX_WIDTH'(i)) begin
                Grant[i] = 1'b1;
                SAddr    = MAddr[32*i +: 32];
                SWE      = MWE[i];
                SRD      = MRD[i];
                SDataOut = MDataOut[32*i +: 32];
                SBurst   = MBurst[12*i +: 12];
            end
        end
        wr_ack = SWE & SWRAck;
        rd_ack = SRD & SRDAck;
        MWRAck = Grant & {NUM_MASTERS{wr_ack}};
        MRDAck = Grant & {NUM_MASTERS{rd_ack}};
    end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Directed bench for vproc_bus_arbiter with four masters.
module tb_vproc_bus_arbiter;

    localparam int N = 4;

    logic           Clk;
    logic           Reset;
    logic [N*32-1:0] MAddr;
    logic [N-1:0]    MWE;
    logic [N-1:0]    MRD;
    logic [N*32-1:0] MDataOut;
    logic [N*12-1:0] MBurst;
    logic [31:0]     MDataIn;
    logic [N-1:0]    MWRAck;
    logic [N-1:0]    MRDAck;
    logic [31:0]     SAddr;
    logic            SWE;
    logic            SRD;
    logic [31:0]     SDataOut;
    logic [11:0]     SBurst;
    logic [31:0]     SDataIn;
    logic            SWRAck;
    logic            SRDAck;
    logic [N-1:0]    Grant;
    logic            Busy;

    int checks   = 0;
    int failures = 0;

    vproc_bus_arbiter #(.NUM_MASTERS(N), .IDX_WIDTH(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .MAddr(MAddr), .MWE(MWE), .MRD(MRD),
        .MDataOut(MDataOut), .MBurst(MBurst),
        .MDataIn(MDataIn), .MWRAck(MWRAck), .MRDAck(MRDAck),
        .SAddr(SAddr), .SWE(SWE), .SRD(SRD),
        .SDataOut(SDataOut), .SBurst(SBurst),
        .SDataIn(SDataIn), .SWRAck(SWRAck), .SRDAck(SRDAck),
        .Grant(Grant), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic drv(input int i, input logic we, input logic rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [11:0] b);
        MWE[i] = we;
        MRD[i] = rd;
        MAddr[32*i +: 32]    = a;
        MDataOut[32*i +: 32] = d;
        MBurst[12*i +: 12]   = b;
    endtask

    logic [3:0] exp_g;

    initial begin
        Reset = 1'b1;
        MAddr = '0; MWE = '0; MRD = '0;
        MDataOut = '0; MBurst = '0;
        SDataIn = 32'hDEADBEEF;
        SWRAck = 1'b0; SRDAck = 1'b0;
        #1;
        chk("rst_grant", Grant, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_swe", SWE, 0);
        chk("rst_saddr", SAddr, 0);
        chk("rdata_bcast", MDataIn, 32'hDEADBEEF);

        // single write from master 1
        tick();
        Reset = 1'b0;
        drv(1, 1'b1, 1'b0, 32'h100, 32'h11112222, 12'd0);
        #1;
        chk("t1_idle_grant", Grant, 0);
        chk("t1_idle_swe", SWE, 0);
        tick(); #1;
        chk("t1_grant", Grant, 4'b0010);
        chk("t1_saddr", SAddr, 32'h100);
        chk("t1_sdata", SDataOut, 32'h11112222);
        chk("t1_swe", SWE, 1);
        chk("t1_noack", MWRAck, 0);
        tick();
        SWRAck = 1'b1;
        #1;
        chk("t1_ack", MWRAck, 4'b0010);
        tick();
        SWRAck = 1'b0;
        drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 12'd0);
        #1;
        chk("t1_done_busy", Busy, 0);
        chk("t1_done_ack", MWRAck, 0);

        // round robin, all reading, fresh priority
        Reset = 1'b1; #1; Reset = 1'b0;
        MRD = 4'hF;
        SRDAck = 1'b1;
        #1;
        chk("rr_idle", Grant, 0);
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            exp_g = 4'b0001 << (k % 4);
            chk("rr_grant", Grant, exp_g);
            chk("rr_ack", MRDAck, exp_g);
            tick();
            if (k == 7) begin
                MRD = '0;
                SRDAck = 1'b0;
            end
            #1;
            chk("rr_gap", Busy, 0);
        end

        // burst lock: master 2 burst of 4, master 0 waiting
        tick();
        drv(2, 1'b1, 1'b0, 32'h200, 32'hA5A5A5A5, 12'd4);
        #1;
        tick(); #1;
        chk("bl_grant", Grant, 4'b0100);
        chk("bl_sburst", SBurst, 12'd4);
        MRD[0] = 1'b1;
        MBurst[23:12] = 12'd0;
        SWRAck = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("bl_hold", Grant, 4'b0100);
            chk("bl_ack", MWRAck, 4'b0100);
            tick();
        end
        SWRAck = 1'b0;
        drv(2, 1'b0, 1'b0, 32'h0, 32'h0, 12'd0);
        #1;
        chk("bl_gap", Grant, 0);
        tick(); #1;
        chk("bl_next", Grant, 4'b0001);
        SRDAck = 1'b1;
        #1;
        chk("bl_next_ack", MRDAck, 4'b0001);
        tick();
        MRD = '0;
        SRDAck = 1'b0;
        #1;
        chk("bl_end", Busy, 0);

        // mismatched acks: master 3 reads
        tick();
        drv(3, 1'b0, 1'b1, 32'h300, 32'h0, 12'd0);
        tick(); #1;
        chk("mm_grant", Grant, 4'b1000);
        chk("mm_saddr", SAddr, 32'h300);
        chk("mm_srd", SRD, 1);
        SWRAck = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mm_nordack", MRDAck, 0);
            chk("mm_nowrack", MWRAck, 0);
            chk("mm_busy", Busy, 1);
            tick();
        end
        SRDAck = 1'b1;
        SDataIn = 32'h12345678;
        #1;
        chk("mm_rdack", MRDAck, 4'b1000);
        chk("mm_both_wr", MWRAck, 0);
        chk("mm_rdata", MDataIn, 32'h12345678);
        tick();
        MRD = '0;
        #1;
        chk("mm_done", Busy, 0);
        chk("idle_wrack", MWRAck, 0);
        chk("idle_rdack", MRDAck, 0);
        SWRAck = 1'b0;
        SRDAck = 1'b0;

        // abort: master 0 burst of 8 drops after 2 acks
        tick();
        drv(0, 1'b0, 1'b1, 32'h400, 32'h0, 12'd8);
        MRD[1] = 1'b1;
        tick(); #1;
        chk("ab_grant", Grant, 4'b0001);
        SRDAck = 1'b1;
        #1;
        chk("ab_ack1", MRDAck, 4'b0001);
        tick(); #1;
        chk("ab_ack2", MRDAck, 4'b0001);
        tick();
        MRD[0] = 1'b0;
        #1;
        chk("ab_drop_ack", MRDAck, 0);
        chk("ab_drop_busy", Busy, 1);
        tick();
        SRDAck = 1'b0;
        #1;
        chk("ab_idle", Busy, 0);
        tick(); #1;
        chk("ab_next", Grant, 4'b0010);
        SRDAck = 1'b1;
        #1;
        chk("ab_next_ack", MRDAck, 4'b0010);
        tick();
        MRD = '0;
        SRDAck = 1'b0;
        #1;

        // reset in beat 3 of a 5-beat write
        tick();
        drv(0, 1'b1, 1'b0, 32'h500, 32'hCAFEF00D, 12'd5);
        tick(); #1;
        chk("rs_grant", Grant, 4'b0001);
        SWRAck = 1'b1;
        tick();
        tick(); #1;
        chk("rs_beat3", MWRAck, 4'b0001);
        MRD[2] = 1'b1;
        Reset = 1'b1;
        #1;
        chk("rs_swe", SWE, 0);
        chk("rs_grant0", Grant, 0);
        chk("rs_busy", Busy, 0);
        chk("rs_saddr", SAddr, 0);
        SWRAck = 1'b0;
        tick(); #1;
        chk("rs_held", Busy, 0);
        Reset = 1'b0;
        tick(); #1;
        chk("rs_prio", Grant, 4'b0001);
        MWE = '0;
        MRD = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vproc_bus_arbiter.md
Name: vproc_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory-mapped slave bus between up to 8 VProc masters.
- Each master port carries the VProc bus signals: address, write enable, read enable, write data, burst count, and per-master write/read acknowledges.
- A grant is locked for a whole transfer, single or burst, and released only after the final beat is acknowledged.
- The block sits between the VProc instances of a multi-node testbench and a single shared memory/peripheral model.

Parameters:
- NUM_MASTERS, 4, number of VProc masters (legal range 2..8).
- IDX_WIDTH, 3, width of the grant index. Must be at least clog2(NUM_MASTERS), minimum 1.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- MAddr  input  NUM_MASTERS*32  per-master address; master i occupies bits [32i+31:32i].
- MWE  input  NUM_MASTERS  per-master write enable.
- MRD  input  NUM_MASTERS  per-master read enable.
- MDataOut  input  NUM_MASTERS*32  per-master write data.
- MBurst  input  NUM_MASTERS*12  per-master burst count; 0 means a single access.
- MDataIn  output  32  read data, SDataIn broadcast to all masters.
- MWRAck  output  NUM_MASTERS  write acknowledge, routed to the granted master only.
- MRDAck  output  NUM_MASTERS  read acknowledge, routed to the granted master only.
- SAddr  output  32  slave address.
- SWE  output  1  slave write enable.
- SRD  output  1  slave read enable.
- SDataOut  output  32  slave write data.
- SBurst  output  12  slave burst count.
- SDataIn  input  32  slave read data.
- SWRAck  input  1  slave write acknowledge.
- SRDAck  input  1  slave read acknowledge.
- Grant  output  NUM_MASTERS  one-hot grant vector; all zero when idle.
- Busy  output  1  high in the BUSY state.

Behaviour:
- Request definition: Req[i] = MWE[i] | MRD[i].
- Registered state: State (IDLE, BUSY), GrantIdx, LastIdx, 12-bit BeatCnt.
- Reset values:
  - State=IDLE, GrantIdx=0, LastIdx=NUM_MASTERS-1 (so master 0 has first priority), BeatCnt=0.
  - All outputs 0: Grant, Busy, SWE, SRD, SAddr, SDataOut, SBurst, MWRAck, MRDAck.
  - MDataIn follows SDataIn at all times.
- IDLE state:
  - If any Req is high, select the first requester searching LastIdx+1, LastIdx+2, ... with modulo NUM_MASTERS wrap.
  - On the next posedge: GrantIdx=selected index, BeatCnt=max(MBurst[sel],1), State=BUSY.
  - If no Req is high, stay in IDLE.
- Slave outputs:
  - Combinational mux of master GrantIdx, gated by Busy; forced to 0 in IDLE.
  - Grant-to-slave latency is one cycle after the request is first seen.
- Acknowledge routing:
  - MWRAck[GrantIdx] = Busy & SWE & SWRAck.
  - MRDAck[GrantIdx] = Busy & SRD & SRDAck.
  - All other ack bits are 0.
  - A slave ack that does not match the active operation (e.g. SRDAck during a write) is not forwarded and is not counted.
- Beat counting:
  - Each forwarded ack is one beat.
  - If BeatCnt>1, decrement and remain BUSY; the master keeps the grant and updates address/data itself.
  - If BeatCnt==1, the transfer completes: State=IDLE, LastIdx=GrantIdx.
- Turnaround: there is always at least one IDLE cycle between grants. A master that re-requests back-to-back competes normally and goes to the back of the rotation.
- Master drops request while BUSY (both MWE and MRD low before the final ack): abandon the transfer, go to IDLE, set LastIdx=GrantIdx. No ack is forwarded in that cycle.
- Simultaneous SWRAck and SRDAck: only the ack matching the granted master's active enable counts.
- Acks arriving in IDLE are ignored.
- Reset asserted mid-transfer: immediate return to IDLE with reset values; slave outputs drop to 0 asynchronously.
- Changes to MBurst while BUSY are ignored; BeatCnt is loaded only at grant.

Test Plan:
- Single write, master 1 only: MWE[1]=1, MAddr=0x100, MBurst=0, slave acks at the 2nd BUSY cycle -> Grant=4'b0010 one cycle after the request; SAddr=0x100; MWRAck[1] pulses for exactly 1 cycle; IDLE on the next cycle.
- Round-robin, all 4 masters reading continuously, slave acks every BUSY cycle -> grant order 0,1,2,3,0,...; each grant lasts 1 cycle, separated by 1 IDLE cycle.
- Burst lock: master 2 writes with MBurst=4 while master 0 also requests -> Grant stays 4'b0100 for exactly 4 forwarded acks; master 0 is granted only after the IDLE cycle that follows.
- Mismatched ack: master 3 reads; the slave asserts SWRAck only for 3 cycles, then SRDAck -> no MRDAck until the SRDAck cycle; completion on that cycle.
- Abort: master 0 starts a burst with MBurst=8, drops MRD after 2 acks -> Busy=0 on the next cycle; LastIdx=0, so master 1 is served next.
- Reset mid-burst: assert Reset during beat 3 of a 5-beat write -> SWE, Grant and Busy go to 0 immediately; after release, master 0 has priority.
